// File: rtl/unbalanced_ram_arbiter_pkg.sv
// Shared constants for the unbalanced RAM arbiter: grant encodings,
// supported RAM read latencies and the lane-index width helper.
package unbalanced_ram_arbiter_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_WR   = 2'd1;
    localparam logic [1:0] GNT_RD   = 2'd2;

    localparam int RAM_LATENCY_MIN = 1;
    localparam int RAM_LATENCY_MAX = 2;

    // Width of the lane field inside a narrow address; never narrower than one bit.
    function automatic int lane_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/unbalanced_ram_arbiter_lane_packer.sv
// Packs in-order narrow lanes into one wide word and parks the finished word
// in a single pending register until the arbiter writes it to the RAM.
module lane_packer
    import unbalanced_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH_A = 64,
    parameter int ADDR_WIDTH_A = 7,
    parameter int DEINTERLEAVE = 2,
    parameter int DATA_WIDTH_B = DATA_WIDTH_A / DEINTERLEAVE,
    parameter int ADDR_WIDTH_B = ADDR_WIDTH_A + $clog2(DEINTERLEAVE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH_B-1:0] wr_addr,
    input  logic [DATA_WIDTH_B-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic                    wr_err,
    input  logic                    pend_grant,
    output logic                    pend_full,
    output logic [ADDR_WIDTH_A-1:0] pend_addr,
    output logic [DATA_WIDTH_A-1:0] pend_data
);

    localparam int LW = lane_width(DEINTERLEAVE);
    localparam int BW = DATA_WIDTH_B * (DEINTERLEAVE - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(DEINTERLEAVE - 1);

    logic [LW-1:0]           lane;
    logic [ADDR_WIDTH_A-1:0] wide_addr;
    logic                    accept;
    logic [DATA_WIDTH_A-1:0] packed_word;

    logic [BW-1:0]           lanes_d, lanes_q;
    logic [ADDR_WIDTH_A-1:0] base_d, base_q;
    logic [LW-1:0]           exp_lane_d, exp_lane_q;
    logic                    err_d, err_q;
    logic                    pend_full_d, pend_full_q;
    logic [ADDR_WIDTH_A-1:0] pend_addr_d, pend_addr_q;
    logic [DATA_WIDTH_A-1:0] pend_data_d, pend_data_q;

    assign lane        = wr_addr[LW-1:0];
    assign wide_addr   = wr_addr[ADDR_WIDTH_B-1:LW];
    assign packed_word = {wr_data, lanes_q};

    // Only the closing lane needs a free pending slot; a slot freed by this
    // cycle's write grant can be refilled at the same edge.
    assign wr_ready = rst_n && !(lane == LAST_LANE && pend_full_q && !pend_grant);
    assign accept   = wr_valid && wr_ready;

    always_comb begin
        lanes_d     = lanes_q;
        base_d      = base_q;
        exp_lane_d  = exp_lane_q;
        err_d       = 1'b0;
        pend_full_d = pend_full_q && !pend_grant;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (accept) begin
            if (lane == '0) begin
                base_d                             = wide_addr;
                lanes_d[0 +: DATA_WIDTH_B]         = wr_data;
                exp_lane_d                         = LW'(1);
            end else if (lane == exp_lane_q && wide_addr == base_q) begin
                if (lane == LAST_LANE) begin
                    pend_full_d = 1'b1;
                    pend_addr_d = base_q;
                    pend_data_d = packed_word;
                    exp_lane_d  = '0;
                end else begin
                    lanes_d[int'(lane) * DATA_WIDTH_B +: DATA_WIDTH_B] = wr_data;
                    exp_lane_d = exp_lane_q + LW'(1);
                end
            end else begin
                // Out-of-order or foreign beat: drop it and the partial word.
                err_d      = 1'b1;
                exp_lane_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lanes_q     <= '0;
            base_q      <= '0;
            exp_lane_q  <= '0;
            err_q       <= 1'b0;
            pend_full_q <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            lanes_q     <= lanes_d;
            base_q      <= base_d;
            exp_lane_q  <= exp_lane_d;
            err_q       <= err_d;
            pend_full_q <= pend_full_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign wr_err    = err_q;
    assign pend_full = pend_full_q;
    assign pend_addr = pend_addr_q;
    assign pend_data = pend_data_q;

endmodule

// File: rtl/unbalanced_ram_arbiter.sv
// Shares the wide RAM port between a packed narrow write stream and a wide
// read requester: one operation per cycle, round-robin, read-after-write safe.
module unbalanced_ram_arbiter
    import unbalanced_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH_A = 64,
    parameter int ADDR_WIDTH_A = 7,
    parameter int DEINTERLEAVE = 2,
    parameter int RAM_LATENCY  = 1,
    parameter int DATA_WIDTH_B = DATA_WIDTH_A / DEINTERLEAVE,
    parameter int ADDR_WIDTH_B = ADDR_WIDTH_A + $clog2(DEINTERLEAVE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH_B-1:0] wr_addr,
    input  logic [DATA_WIDTH_B-1:0] wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic                    wr_err,
    input  logic [ADDR_WIDTH_A-1:0] rd_addr,
    input  logic                    rd_valid,
    output logic                    rd_ready,
    output logic [DATA_WIDTH_A-1:0] rd_data,
    output logic                    rd_data_valid,
    output logic [ADDR_WIDTH_A-1:0] ram_addr,
    output logic [DATA_WIDTH_A-1:0] ram_din,
    output logic                    ram_en,
    output logic                    ram_we,
    input  logic [DATA_WIDTH_A-1:0] ram_dout
);

    if (RAM_LATENCY < RAM_LATENCY_MIN || RAM_LATENCY > RAM_LATENCY_MAX) begin : g_bad_latency
        $error("unbalanced_ram_arbiter: unsupported RAM_LATENCY");
    end

    logic                    pend_full;
    logic [ADDR_WIDTH_A-1:0] pend_addr;
    logic [DATA_WIDTH_A-1:0] pend_data;
    logic [1:0]              grant;

    logic [1:0]              last_grant_d, last_grant_q;
    logic [ADDR_WIDTH_A-1:0] ram_addr_d, ram_addr_q;
    logic [DATA_WIDTH_A-1:0] ram_din_d, ram_din_q;
    logic [RAM_LATENCY-1:0]  rd_vpipe_d, rd_vpipe_q;
    logic                    rd_data_valid_d, rd_data_valid_q;
    logic [DATA_WIDTH_A-1:0] rd_data_d, rd_data_q;

    lane_packer #(
        .DATA_WIDTH_A (DATA_WIDTH_A),
        .ADDR_WIDTH_A (ADDR_WIDTH_A),
        .DEINTERLEAVE (DEINTERLEAVE),
        .DATA_WIDTH_B (DATA_WIDTH_B),
        .ADDR_WIDTH_B (ADDR_WIDTH_B)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_err     (wr_err),
        .pend_grant (grant == GNT_WR),
        .pend_full  (pend_full),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data)
    );

    // A read of the pending word's address must see the new data, so the
    // write is forced ahead of it regardless of whose turn it is.
    always_comb begin
        grant = GNT_NONE;
        if (rst_n) begin
            if (pend_full && rd_valid) begin
                if (pend_addr == rd_addr || last_grant_q == GNT_RD) begin
                    grant = GNT_WR;
                end else begin
                    grant = GNT_RD;
                end
            end else if (pend_full) begin
                grant = GNT_WR;
            end else if (rd_valid) begin
                grant = GNT_RD;
            end
        end
    end

    assign rd_ready = (grant == GNT_RD);
    assign ram_en   = (grant != GNT_NONE);
    assign ram_we   = (grant == GNT_WR);

    always_comb begin
        ram_addr = ram_addr_q;
        ram_din  = ram_din_q;
        if (!rst_n) begin
            ram_addr = '0;
            ram_din  = '0;
        end else if (grant == GNT_WR) begin
            ram_addr = pend_addr;
            ram_din  = pend_data;
        end else if (grant == GNT_RD) begin
            ram_addr = rd_addr;
        end
        ram_addr_d   = ram_addr;
        ram_din_d    = ram_din;
        last_grant_d = (grant != GNT_NONE) ? grant : last_grant_q;
    end

    // Each stage marks a read whose data is travelling through the RAM.
    always_comb begin
        rd_vpipe_d    = rd_vpipe_q;
        rd_vpipe_d[0] = rd_ready;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            rd_vpipe_d[i] = rd_vpipe_q[i-1];
        end
        rd_data_valid_d = rd_vpipe_q[RAM_LATENCY-1];
        rd_data_d       = rd_vpipe_q[RAM_LATENCY-1] ? ram_dout : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q    <= GNT_RD;
            ram_addr_q      <= '0;
            ram_din_q       <= '0;
            rd_vpipe_q      <= '0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            last_grant_q    <= last_grant_d;
            ram_addr_q      <= ram_addr_d;
            ram_din_q       <= ram_din_d;
            rd_vpipe_q      <= rd_vpipe_d;
            rd_data_valid_q <= rd_data_valid_d;
            rd_data_q       <= rd_data_d;
        end
    end

    assign rd_data_valid = rd_data_valid_q;
    assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_unbalanced_ram_arbiter.sv
// Bench for unbalanced_ram_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the arbiter rules.
module tb_unbalanced_ram_arbiter;

    localparam int DWA = 64;
    localparam int AWA = 7;
    localparam int D   = 2;
    localparam int RL  = 2;
    localparam int DWB = DWA / D;
    localparam int AWB = AWA + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AWB-1:0] wr_addr = '0;
    logic [DWB-1:0] wr_data = '0;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic           wr_err;
    logic [AWA-1:0] rd_addr = '0;
    logic           rd_valid = 1'b0;
    logic           rd_ready;
    logic [DWA-1:0] rd_data;
    logic           rd_data_valid;
    logic [AWA-1:0] ram_addr;
    logic [DWA-1:0] ram_din;
    logic           ram_en;
    logic           ram_we;
    logic [DWA-1:0] ram_dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    unbalanced_ram_arbiter #(
        .DATA_WIDTH_A (DWA),
        .ADDR_WIDTH_A (AWA),
        .DEINTERLEAVE (D),
        .RAM_LATENCY  (RL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_err        (wr_err),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_dout      (ram_dout)
    );

    // RAM with RL cycles of read latency; contents survive arbiter reset.
    logic [DWA-1:0] ram_mem [128];
    logic [DWA-1:0] ram_s1 = '0;
    logic [DWA-1:0] ram_s2 = '0;
    initial for (int i = 0; i < 128; i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_en && ram_we) ram_mem[ram_addr] <= ram_din;
        if (ram_en && !ram_we) ram_s1 <= ram_mem[ram_addr];
        ram_s2 <= ram_s1;
    end
    assign ram_dout = ram_s2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int             cyc = 0;
    bit             m_pend_full;
    logic [AWA-1:0] m_pend_addr;
    logic [DWA-1:0] m_pend_data;
    int             m_exp_lane;
    logic [AWA-1:0] m_base;
    logic [DWB-1:0] m_lane0;
    bit             m_last_wr;
    bit             m_err_next;
    bit             m_after_rst;
    logic [AWA-1:0] m_hold_addr;
    logic [DWA-1:0] m_hold_din;
    logic [DWA-1:0] m_mem [128];
    logic [DWA-1:0] exp_q [$];
    int             due_q [$];

    // observation logs used by the directed scenarios
    int             wr_cnt;
    logic [AWA-1:0] last_w_addr;
    logic [DWA-1:0] last_w_din;
    int             gnt_log [$];
    int             hs_cyc [$];
    int             rdv_cyc [$];
    logic [DWA-1:0] rdv_data [$];

    initial for (int i = 0; i < 128; i++) m_mem[i] = '0;

    task automatic model_reset();
        m_pend_full = 0;
        m_pend_addr = '0;
        m_pend_data = '0;
        m_exp_lane  = 0;
        m_base      = '0;
        m_lane0     = '0;
        m_last_wr   = 0;
        m_err_next  = 0;
        m_hold_addr = '0;
        m_hold_din  = '0;
        exp_q.delete();
        due_q.delete();
    endtask

    always @(negedge clk) begin : model_check
        int             lane;
        logic [AWA-1:0] waddr;
        bit             gw, gr, ew;
        if (!rst_n) begin
            check_eq("rst_wr_ready", wr_ready, 0);
            check_eq("rst_rd_ready", rd_ready, 0);
            check_eq("rst_ram_en", ram_en, 0);
            check_eq("rst_ram_we", ram_we, 0);
            check_eq("rst_ram_addr", ram_addr, 0);
            check_eq("rst_ram_din", ram_din, 0);
            model_reset();
            m_after_rst = 1;
        end else begin
            cyc++;
            if (m_after_rst) begin
                check_eq("rst_rd_data", rd_data, 0);
                m_after_rst = 0;
            end
            lane  = int'(wr_addr[0]);
            waddr = wr_addr[AWB-1:1];
            gw = m_pend_full && (!rd_valid || m_pend_addr == rd_addr || !m_last_wr);
            gr = rd_valid && !gw;
            ew = !(lane == D - 1 && m_pend_full && !gw);

            check_eq("wr_ready", wr_ready, ew);
            check_eq("rd_ready", rd_ready, gr);
            check_eq("ram_en", ram_en, gw || gr);
            check_eq("ram_we", ram_we, gw);
            if (gw) begin
                check_eq("wr_ram_addr", ram_addr, m_pend_addr);
                check_eq("wr_ram_din", ram_din, m_pend_data);
            end else if (gr) begin
                check_eq("rd_ram_addr", ram_addr, rd_addr);
            end else begin
                check_eq("idle_ram_addr", ram_addr, m_hold_addr);
                check_eq("idle_ram_din", ram_din, m_hold_din);
            end
            check_eq("wr_err", wr_err, m_err_next);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                check_eq("rd_data_valid", rd_data_valid, 1);
                check_eq("rd_data", rd_data, exp_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                check_eq("rd_data_valid_idle", rd_data_valid, 0);
            end

            if (ram_en && ram_we) begin
                wr_cnt++;
                last_w_addr = ram_addr;
                last_w_din  = ram_din;
            end
            if (ram_en) gnt_log.push_back(ram_we ? 1 : 2);
            if (rd_valid && rd_ready) hs_cyc.push_back(cyc);
            if (rd_data_valid) begin
                rdv_cyc.push_back(cyc);
                rdv_data.push_back(rd_data);
            end

            if (gw) begin
                m_hold_addr = m_pend_addr;
                m_hold_din  = m_pend_data;
                m_pend_full = 0;
                m_last_wr   = 1;
            end
            if (gr) begin
                exp_q.push_back(m_mem[rd_addr]);
                due_q.push_back(cyc + RL + 1);
                m_hold_addr = rd_addr;
                m_last_wr   = 0;
            end
            m_err_next = 0;
            if (wr_valid && ew) begin
                if (lane == 0) begin
                    m_base     = waddr;
                    m_lane0    = wr_data;
                    m_exp_lane = 1;
                end else if (lane == m_exp_lane && waddr == m_base) begin
                    m_pend_full   = 1;
                    m_pend_addr   = m_base;
                    m_pend_data   = {wr_data, m_lane0};
                    m_mem[m_base] = {wr_data, m_lane0};
                    m_exp_lane    = 0;
                end else begin
                    m_err_next = 1;
                    m_exp_lane = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit w_acc, r_acc;

    task automatic step();
        @(negedge clk);
        w_acc = wr_valid && wr_ready;
        r_acc = rd_valid && rd_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic beat(input logic [AWB-1:0] a, input logic [DWB-1:0] d);
        int budget;
        wr_valid = 1;
        wr_addr  = a;
        wr_data  = d;
        budget   = 0;
        do begin
            step();
            budget++;
        end while (!w_acc && budget < 20);
        if (!w_acc) check_eq("wr_accept_timeout", budget, 0);
        wr_valid = 0;
    endtask

    task automatic do_reset();
        wr_valid = 0;
        rd_valid = 0;
        rst_n    = 0;
        step();
        rst_n    = 1;
    endtask

    task automatic clear_logs();
        wr_cnt = 0;
        gnt_log.delete();
        hs_cyc.delete();
        rdv_cyc.delete();
        rdv_data.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int budget;
        int g_lane, g_wide;
        bit bad;
        model_reset();
        clear_logs();
        @(posedge clk);
        #1;
        do_reset();

        // Two in-order lanes form one wide write.
        clear_logs();
        beat(8'h10, 32'hAAAA_AAAA);
        beat(8'h11, 32'hBBBB_BBBB);
        idle(3);
        check_eq("t1_wr_count", wr_cnt, 1);
        check_eq("t1_wr_addr", last_w_addr, 7'h08);
        check_eq("t1_wr_din", last_w_din, 64'hBBBB_BBBB_AAAA_AAAA);

        // Lane 1 for a different wide address is dropped with an error.
        clear_logs();
        beat(8'h10, 32'h1111_1111);
        beat(8'h13, 32'h2222_2222);
        idle(3);
        check_eq("t2_no_write", wr_cnt, 0);
        beat(8'h14, 32'h3333_3333);
        beat(8'h15, 32'h4444_4444);
        idle(3);
        check_eq("t2_recover_count", wr_cnt, 1);
        check_eq("t2_recover_addr", last_w_addr, 7'h0A);
        check_eq("t2_recover_din", last_w_din, 64'h4444_4444_3333_3333);

        // Write and read contend every other cycle: grants alternate, write first.
        do_reset();
        beat(8'h40, 32'hC0C0_0000);
        beat(8'h41, 32'hC0C0_0001);
        clear_logs();
        rd_valid = 1;
        rd_addr  = 7'h70;
        beat(8'h42, 32'hC0C0_0002);
        beat(8'h43, 32'hC0C0_0003);
        beat(8'h44, 32'hC0C0_0004);
        beat(8'h45, 32'hC0C0_0005);
        rd_valid = 0;
        idle(6);
        check_eq("t3_grant_count", gnt_log.size() >= 4, 1);
        if (gnt_log.size() >= 4) begin
            check_eq("t3_grant0_wr", gnt_log[0], 1);
            check_eq("t3_grant1_rd", gnt_log[1], 2);
            check_eq("t3_grant2_wr", gnt_log[2], 1);
            check_eq("t3_grant3_rd", gnt_log[3], 2);
        end

        // Read of the pending address after a write grant: write still goes first.
        do_reset();
        beat(8'h10, 32'h0000_0001);
        beat(8'h11, 32'h0000_0002);
        idle(2);
        beat(8'h10, 32'h5A5A_0010);
        beat(8'h11, 32'hA5A5_0011);
        clear_logs();
        rd_valid = 1;
        rd_addr  = 7'h08;
        budget   = 0;
        do begin
            step();
            budget++;
        end while (!r_acc && budget < 20);
        if (!r_acc) check_eq("t4_rd_timeout", budget, 0);
        rd_valid = 0;
        idle(6);
        check_eq("t4_grant_count", gnt_log.size(), 2);
        if (gnt_log.size() >= 2) begin
            check_eq("t4_first_wr", gnt_log[0], 1);
            check_eq("t4_then_rd", gnt_log[1], 2);
        end
        check_eq("t4_rd_count", rdv_data.size(), 1);
        if (rdv_data.size() >= 1) check_eq("t4_rd_new_word", rdv_data[0], 64'hA5A5_0011_5A5A_0010);

        // Four back-to-back reads stream out on consecutive cycles.
        clear_logs();
        rd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 7'(8 + i);
            step();
        end
        rd_valid = 0;
        idle(6);
        check_eq("t5_hs_count", hs_cyc.size(), 4);
        check_eq("t5_rdv_count", rdv_cyc.size(), 4);
        if (hs_cyc.size() == 4 && rdv_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("t5_hs_cycle", hs_cyc[i], hs_cyc[0] + i);
                check_eq("t5_rdv_cycle", rdv_cyc[i], hs_cyc[0] + RL + 1 + i);
            end
        end

        // Reset with a partial word, a pending word and a read in flight.
        do_reset();
        beat(8'h20, 32'h0000_0020);
        beat(8'h21, 32'h0000_0021);
        beat(8'h22, 32'h0000_0022);
        beat(8'h23, 32'h0000_0023);
        wr_valid = 1;
        wr_addr  = 8'h30;
        wr_data  = 32'h0000_0030;
        rd_valid = 1;
        rd_addr  = 7'h03;
        step();
        check_eq("t6_setup_wr", w_acc, 1);
        check_eq("t6_setup_rd", r_acc, 1);
        clear_logs();
        do_reset();
        idle(8);
        check_eq("t6_no_write", wr_cnt, 0);
        check_eq("t6_no_rd_data", rdv_cyc.size(), 0);

        // Random traffic over a small address window to provoke hazards.
        g_lane = 0;
        g_wide = 0;
        bad    = 0;
        w_acc  = 0;
        r_acc  = 0;
        for (int c = 0; c < 3000; c++) begin
            if (w_acc) begin
                if (bad) begin
                    g_lane = 0;
                end else begin
                    g_lane++;
                    if (g_lane == D) begin
                        g_lane = 0;
                        g_wide = $urandom_range(0, 7);
                    end
                end
            end
            if (!wr_valid || w_acc) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                bad      = ($urandom_range(0, 9) == 0);
                wr_addr  = bad ? 8'($urandom_range(0, 15)) : 8'({g_wide[2:0], g_lane[0]});
                wr_data  = $urandom;
            end
            if (!rd_valid || r_acc) begin
                rd_valid = ($urandom_range(0, 1) != 0);
                rd_addr  = 7'($urandom_range(0, 7));
            end
            rst_n = ($urandom_range(0, 499) != 0);
            if (!rst_n) g_lane = 0;
            step();
        end
        rst_n    = 1;
        wr_valid = 0;
        rd_valid = 0;
        idle(8);
        check_eq("drain_reads", due_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
